// File: rtl/aha_ahb_code_loader_if.sv
// Stream input and AHB-Lite initiator bus of the code loader.
// The master modport is the loader side; the slave modport is the surrounding system.
interface aha_ahb_code_loader_if;
  logic        DATA_VALID;
  logic [31:0] DATA_IN;
  logic        DATA_READY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  modport master (
    input  DATA_VALID, DATA_IN, HREADY, HRESP,
    output DATA_READY, HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output DATA_VALID, DATA_IN, HREADY, HRESP,
    input  DATA_READY, HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/aha_ahb_code_loader.sv
// Boot-time loader: copies a stream of 32-bit words into consecutive word addresses
// using pipelined single AHB-Lite writes, reporting count, completion and bus errors.
module aha_ahb_code_loader (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         START,
  input  logic [31:0]                  START_ADDR,
  input  logic [15:0]                  NUM_WORDS,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERROR,
  output logic [15:0]                  WORDS_DONE,
  aha_ahb_code_loader_if.master        bus
);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        dphase_q, dphase_d;
  logic [15:0] words_q, words_d;
  logic        error_q, error_d;

  logic err_first;
  logic addr_issue;
  logic addr_done;
  logic accept;
  logic unused_bits;

  // First cycle of a two-cycle ERROR response: the pending address phase is withdrawn.
  assign err_first  = dphase_q & bus.HRESP[0] & ~bus.HREADY;
  assign addr_issue = buf_valid_q & ~err_first;
  assign addr_done  = addr_issue & bus.HREADY;

  assign bus.DATA_READY = (state_q == StRun) & (rem_q != 16'd0) & ~err_first &
                          (~buf_valid_q | bus.HREADY);
  assign accept         = bus.DATA_VALID & bus.DATA_READY;

  assign unused_bits = ^{bus.HRESP[1], START_ADDR[1:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    hwdata_d    = hwdata_q;
    dphase_d    = dphase_q;
    words_d     = words_q;
    error_d     = error_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          addr_d      = {START_ADDR[31:2], 2'b00};
          rem_d       = NUM_WORDS;
          words_d     = 16'd0;
          error_d     = 1'b0;
          buf_valid_d = 1'b0;
          dphase_d    = 1'b0;
          state_d     = (NUM_WORDS == 16'd0) ? StFin : StRun;
        end
      end

      StRun, StDrain: begin
        if (addr_done) begin
          hwdata_d    = buf_data_q;
          addr_d      = addr_q + 32'd4;
          buf_valid_d = 1'b0;
        end
        // Refill in the same edge the buffered word leaves for its address phase.
        if (accept) begin
          buf_valid_d = 1'b1;
          buf_data_d  = bus.DATA_IN;
          rem_d       = rem_q - 16'd1;
        end
        if (bus.HREADY) begin
          dphase_d = addr_done;
          if (dphase_q) begin
            if (bus.HRESP[0]) begin
              error_d = 1'b1;
            end else begin
              words_d = words_q + 16'd1;
            end
          end
        end

        if (err_first) begin
          error_d     = 1'b1;
          buf_valid_d = 1'b0;
          state_d     = StDrain;
        end else if (state_q == StRun) begin
          if ((rem_d == 16'd0) && !buf_valid_d) begin
            state_d = StDrain;
          end
        end else if (!dphase_q || bus.HREADY) begin
          state_d = StFin;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      addr_q      <= 32'd0;
      rem_q       <= 16'd0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'd0;
      hwdata_q    <= 32'd0;
      dphase_q    <= 1'b0;
      words_q     <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      hwdata_q    <= hwdata_d;
      dphase_q    <= dphase_d;
      words_q     <= words_d;
      error_q     <= error_d;
    end
  end

  assign bus.HTRANS = addr_issue ? HtransNonseq : HtransIdle;
  assign bus.HWRITE = addr_issue;
  assign bus.HADDR  = addr_q;
  assign bus.HWDATA = hwdata_q;
  assign bus.HSIZE  = 3'b010;
  assign bus.HBURST = 3'b000;
  assign bus.HPROT  = 4'b0011;

  assign BUSY       = (state_q != StIdle);
  assign DONE       = (state_q == StFin);
  assign ERROR      = error_q;
  assign WORDS_DONE = words_q;

endmodule

// File: tb/tb_aha_ahb_code_loader.sv
// Bench for aha_ahb_code_loader: table of load scenarios with per-cycle bus expectations,
// an AHB write scoreboard, plus hand-written reset-mid-load sequence.
module tb_aha_ahb_code_loader;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        START;
  logic [31:0] START_ADDR;
  logic [15:0] NUM_WORDS;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [15:0] WORDS_DONE;

  aha_ahb_code_loader_if bus ();

  aha_ahb_code_loader dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .START      (START),
    .START_ADDR (START_ADDR),
    .NUM_WORDS  (NUM_WORDS),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .WORDS_DONE (WORDS_DONE),
    .bus        (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } wr_t;

  typedef struct {
    logic [31:0] start_addr;
    logic [15:0] num_words;
    logic [31:0] data_base;
    logic [15:0] valid_mask;  // bit i = DATA_VALID in cycle i+1
    int          stall_cyc;   // HREADY=0 from this cycle (0 = none)
    int          stall_len;
    logic [31:0] stall_addr;
    logic [31:0] stall_data;
    int          err_cyc;     // first error cycle (0 = none)
    int          restart_cyc; // extra START while busy (0 = none)
    logic [31:0] ns_mask;     // bit c = HTRANS NONSEQ in cycle c
    int          done_cyc;
    int          nwr;
    int          err_idx;
    logic [15:0] exp_wd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];
  wr_t  exp_q [$];
  wr_t  got_q [$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_err = 1'b0;

  // Slave-side observer: logs every completed data phase.
  logic        dp_valid;
  logic [31:0] dp_addr;
  always @(negedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_addr  <= 32'd0;
    end else if (bus.HREADY) begin
      if (dp_valid) got_q.push_back({dp_addr, bus.HWDATA, bus.HRESP[0]});
      dp_valid <= (bus.HTRANS == 2'b10);
      dp_addr  <= bus.HADDR;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_sb(input int id);
    wr_t e;
    wr_t g;
    chk($sformatf("v%0d write count", id), 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk($sformatf("v%0d wr addr", id), g.addr, e.addr);
      chk($sformatf("v%0d wr data", id), g.data, e.data);
      chk($sformatf("v%0d wr resp", id), 32'(g.err), 32'(e.err));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic run_load(input vec_t v, input int id);
    int          idx;
    logic [31:0] base_addr;
    logic        vbit;
    logic        in_stall;
    logic        exp_e;
    idx       = 0;
    base_addr = {v.start_addr[31:2], 2'b00};
    for (int j = 0; j < v.nwr; j++) begin
      exp_q.push_back({base_addr + 32'(4 * j), v.data_base + 32'(j), (j == v.err_idx)});
    end
    for (int cyc = 0; cyc <= v.done_cyc + 1; cyc++) begin
      START = (cyc == 0) || (v.restart_cyc != 0 && cyc == v.restart_cyc);
      if (cyc == 0) begin
        START_ADDR = v.start_addr;
        NUM_WORDS  = v.num_words;
      end else if (START) begin
        START_ADDR = 32'h0000_0900;
        NUM_WORDS  = 16'd9;
      end
      vbit = (cyc != 0);
      if (cyc >= 1 && cyc <= 16) vbit = v.valid_mask[cyc-1];
      bus.DATA_VALID = vbit && (idx < int'(v.num_words));
      bus.DATA_IN    = v.data_base + 32'(idx);
      in_stall   = (v.stall_cyc != 0) && (cyc >= v.stall_cyc) && (cyc < v.stall_cyc + v.stall_len);
      bus.HREADY = !(in_stall || (v.err_cyc != 0 && cyc == v.err_cyc));
      bus.HRESP  = (v.err_cyc != 0 && (cyc == v.err_cyc || cyc == v.err_cyc + 1)) ? 2'b01 : 2'b00;

      @(negedge HCLK);
      exp_e = (cyc == 0) ? prev_err : (v.err_cyc != 0 && cyc > v.err_cyc);
      chk($sformatf("v%0d c%0d HTRANS", id, cyc), 32'(bus.HTRANS),
          v.ns_mask[cyc] ? 32'd2 : 32'd0);
      chk($sformatf("v%0d c%0d HWRITE", id, cyc), 32'(bus.HWRITE), 32'(v.ns_mask[cyc]));
      chk($sformatf("v%0d c%0d BUSY", id, cyc), 32'(BUSY), 32'(cyc >= 1 && cyc <= v.done_cyc));
      chk($sformatf("v%0d c%0d DONE", id, cyc), 32'(DONE), 32'(cyc == v.done_cyc));
      chk($sformatf("v%0d c%0d ERROR", id, cyc), 32'(ERROR), 32'(exp_e));
      if (cyc == 1) chk($sformatf("v%0d cleared WORDS_DONE", id), 32'(WORDS_DONE), 32'd0);
      if (cyc == v.done_cyc) chk($sformatf("v%0d WORDS_DONE", id), 32'(WORDS_DONE), 32'(v.exp_wd));
      if (in_stall) begin
        chk($sformatf("v%0d c%0d stall HADDR", id, cyc), bus.HADDR, v.stall_addr);
        chk($sformatf("v%0d c%0d stall HWDATA", id, cyc), bus.HWDATA, v.stall_data);
        chk($sformatf("v%0d c%0d stall DATA_READY", id, cyc), 32'(bus.DATA_READY), 32'd0);
      end
      if (v.err_cyc != 0 && cyc == v.err_cyc) begin
        chk($sformatf("v%0d err DATA_READY", id), 32'(bus.DATA_READY), 32'd0);
      end
      if (bus.DATA_VALID && bus.DATA_READY) idx++;
      @(posedge HCLK);
      #1;
    end
    START          = 1'b0;
    bus.DATA_VALID = 1'b0;
    bus.HREADY     = 1'b1;
    bus.HRESP      = 2'b00;
    prev_err       = v.exp_err;
    check_sb(id);
  endtask

  initial begin
    HRESETn        = 1'b0;
    START          = 1'b0;
    START_ADDR     = 32'd0;
    NUM_WORDS      = 16'd0;
    bus.DATA_VALID = 1'b0;
    bus.DATA_IN    = 32'd0;
    bus.HREADY     = 1'b1;
    bus.HRESP      = 2'b00;

    //          start        n      base    vmask    stall       st_addr st_data err rst ns_mask done nwr eidx wd err
    vecs[0] = '{32'h100,     16'd4, 32'hA0, 16'hFFFF, 0, 0, 32'h0,   32'h0,  0,  0,  32'h03C, 7,  4, -1, 16'd4, 1'b0};
    vecs[1] = '{32'h100,     16'd4, 32'hA0, 16'hFFFF, 4, 2, 32'h108, 32'hA1, 0,  0,  32'h0FC, 9,  4, -1, 16'd4, 1'b0};
    vecs[2] = '{32'h200,     16'd3, 32'hB0, 16'hFFF9, 0, 0, 32'h0,   32'h0,  0,  0,  32'h064, 8,  3, -1, 16'd3, 1'b0};
    vecs[3] = '{32'h300,     16'd5, 32'hC0, 16'hFFFF, 0, 0, 32'h0,   32'h0,  4,  0,  32'h00C, 6,  2,  1, 16'd1, 1'b1};
    vecs[4] = '{32'h400,     16'd0, 32'hD0, 16'hFFFF, 0, 0, 32'h0,   32'h0,  0,  0,  32'h000, 1,  0, -1, 16'd0, 1'b0};
    vecs[5] = '{32'hFFFFFFFC,16'd2, 32'hE0, 16'hFFFF, 0, 0, 32'h0,   32'h0,  0,  2,  32'h00C, 5,  2, -1, 16'd2, 1'b0};
    vecs[6] = '{32'h1003,    16'd1, 32'hF0, 16'hFFFF, 0, 0, 32'h0,   32'h0,  0,  0,  32'h004, 4,  1, -1, 16'd1, 1'b0};
    vecs[7] = '{32'h500,     16'd4, 32'h50, 16'h5555, 0, 0, 32'h0,   32'h0,  0,  0,  32'h154, 10, 4, -1, 16'd4, 1'b0};

    #3;
    chk("reset HTRANS", 32'(bus.HTRANS), 32'd0);
    chk("reset HADDR", bus.HADDR, 32'd0);
    chk("reset HWDATA", bus.HWDATA, 32'd0);
    chk("reset HWRITE", 32'(bus.HWRITE), 32'd0);
    chk("reset DATA_READY", 32'(bus.DATA_READY), 32'd0);
    chk("reset BUSY", 32'(BUSY), 32'd0);
    chk("reset DONE", 32'(DONE), 32'd0);
    chk("reset ERROR", 32'(ERROR), 32'd0);
    chk("reset WORDS_DONE", 32'(WORDS_DONE), 32'd0);
    chk("HSIZE", 32'(bus.HSIZE), 32'd2);
    chk("HBURST", 32'(bus.HBURST), 32'd0);
    chk("HPROT", 32'(bus.HPROT), 32'd3);
    #9;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    for (int i = 0; i < 8; i++) run_load(vecs[i], i);

    // Reset asserted while word 1 is in its address phase and word 0 in its data phase.
    START          = 1'b1;
    START_ADDR     = 32'h700;
    NUM_WORDS      = 16'd4;
    @(posedge HCLK);
    #1;
    START          = 1'b0;
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 32'h77;
    @(posedge HCLK);
    #1;
    @(posedge HCLK);
    #1;
    chk("pre-reset HTRANS", 32'(bus.HTRANS), 32'd2);
    chk("pre-reset HADDR", bus.HADDR, 32'h704);
    chk("pre-reset HWDATA", bus.HWDATA, 32'h77);
    chk("pre-reset BUSY", 32'(BUSY), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("mid reset HTRANS", 32'(bus.HTRANS), 32'd0);
    chk("mid reset HWRITE", 32'(bus.HWRITE), 32'd0);
    chk("mid reset HADDR", bus.HADDR, 32'd0);
    chk("mid reset HWDATA", bus.HWDATA, 32'd0);
    chk("mid reset DATA_READY", 32'(bus.DATA_READY), 32'd0);
    chk("mid reset BUSY", 32'(BUSY), 32'd0);
    chk("mid reset WORDS_DONE", 32'(WORDS_DONE), 32'd0);
    bus.DATA_VALID = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    got_q.delete();
    exp_q.delete();
    prev_err = 1'b0;
    @(posedge HCLK);
    #1;

    run_load(vecs[6], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
